// File: rtl/enum_types.sv
// Shared level enumeration used by the ramp sequencer and its consumers.
package enum_types;
  typedef enum logic [5:0] {
    E_NONE   = 6'd0,
    E_LOW    = 6'd10,
    E_MEDIUM = 6'd20,
    E_HIGH   = 6'd30,
    E_MAX    = 6'd40
  } level_e;
endpackage

// File: rtl/enum_level_ramp_ctrl.sv
// Ramps a registered level_e one member per dwell period toward a requested target.
// Optional step counter output enabled by defining ENUM_RAMP_STEP_CNT_EN.
module enum_level_ramp_ctrl
  import enum_types::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter level_e      RESET_LEVEL  = E_NONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  level_e       req_target,
  output logic         req_ready,
  input  logic         abort,
  output level_e       level_out,
  output logic [2:0]   level_idx,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         aborted
`ifdef ENUM_RAMP_STEP_CNT_EN
  ,output logic [15:0] step_cnt
`endif
);

  if (DWELL_CYCLES == 0 || DWELL_CYCLES > 255) begin : g_bad_dwell
    $error("DWELL_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_e;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL_CYCLES - 1);

  function automatic logic is_member(input level_e l);
    case (l)
      E_NONE, E_LOW, E_MEDIUM, E_HIGH, E_MAX: is_member = 1'b1;
      default:                                is_member = 1'b0;
    endcase
  endfunction

  function automatic level_e step_up(input level_e l);
    case (l)
      E_NONE:   step_up = E_LOW;
      E_LOW:    step_up = E_MEDIUM;
      E_MEDIUM: step_up = E_HIGH;
      E_HIGH:   step_up = E_MAX;
      default:  step_up = l;
    endcase
  endfunction

  function automatic level_e step_down(input level_e l);
    case (l)
      E_MAX:    step_down = E_HIGH;
      E_HIGH:   step_down = E_MEDIUM;
      E_MEDIUM: step_down = E_LOW;
      E_LOW:    step_down = E_NONE;
      default:  step_down = l;
    endcase
  endfunction

  function automatic logic [2:0] ordinal(input level_e l);
    case (l)
      E_LOW:    ordinal = 3'd1;
      E_MEDIUM: ordinal = 3'd2;
      E_HIGH:   ordinal = 3'd3;
      E_MAX:    ordinal = 3'd4;
      default:  ordinal = 3'd0;
    endcase
  endfunction

  state_e     state_q, state_d;
  level_e     level_q, level_d;
  level_e     target_q, target_d;
  logic       up_q, up_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q;
  logic       err_q, err_d;
  logic       aborted_q, aborted_d;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    target_d  = target_q;
    up_d      = up_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!is_member(req_target)) begin
            err_d = 1'b1;
          end else if (req_target == level_q) begin
            target_d = req_target;
            state_d  = S_DONE;
          end else begin
            target_d = req_target;
            up_d     = (req_target > level_q);
            cnt_d    = CNT_LOAD;
            state_d  = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        // abort outranks a step that falls on the same edge
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          level_d = up_q ? step_up(level_q) : step_down(level_q);
          if (level_d == target_q) state_d = S_DONE;
          else                     cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      level_q   <= RESET_LEVEL;
      idx_q     <= ordinal(RESET_LEVEL);
      target_q  <= RESET_LEVEL;
      up_q      <= 1'b0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      idx_q     <= ordinal(level_d);
      target_q  <= target_d;
      up_q      <= up_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_DWELL);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign aborted   = aborted_q;
  assign level_out = level_q;
  assign level_idx = idx_q;

`ifdef ENUM_RAMP_STEP_CNT_EN
  logic        step_en;
  logic [15:0] step_q;

  assign step_en = (state_q == S_DWELL) && !abort && (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             step_q <= 16'd0;
    else if (step_en && step_q != 16'hFFFF) step_q <= step_q + 16'd1;
  end

  assign step_cnt = step_q;
`endif

endmodule

// File: doc/enum_level_ramp_ctrl.md
Name: enum_level_ramp_ctrl

Overview:
- Sequencer that ramps a registered `enum_types::level_e` value from its current level to a requested target level.
- Moves one enum member per step, using the enum's `next()` / `prev()` ordering: E_NONE=0, E_LOW=10, E_MEDIUM=20, E_HIGH=30, E_MAX=40.
- Holds each level for a programmable dwell before the next step.
- Sits between a requester (valid/ready) and any consumer of the level value, e.g. power or priority level logic.

Parameters:
- DWELL_CYCLES, 4, clock cycles per step (legal values 1..255; 0 is an elaboration error).
- RESET_LEVEL, enum_types::E_NONE, value of level_out after reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_target  input  level_e  requested target level; may carry a non-member value.
- req_ready  output  1  high only in IDLE (combinational from state).
- abort  input  1  cancel an in-progress ramp.
- level_out  output  level_e  current registered level.
- level_idx  output  3  ordinal of level_out (0..4).
- busy  output  1  high in DWELL.
- done  output  1  one-cycle pulse when a ramp completes.
- err  output  1  one-cycle pulse when a request is rejected.
- aborted  output  1  one-cycle pulse when a ramp is cancelled.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, level_out=RESET_LEVEL, level_idx=ordinal of RESET_LEVEL.
  - busy=0, done=0, err=0, aborted=0, dwell counter=0, req_ready=1.
- States: IDLE, DWELL, DONE.
- IDLE, acceptance: a request is accepted on the edge where req_valid && req_ready. req_target is latched at that edge.
  - Non-member target (not one of 0/10/20/30/40): err=1 for one cycle, state stays IDLE, level unchanged.
  - Target equal to level_out: go to DONE, no step.
  - Otherwise: direction = up if target > level_out numerically, else down. Load counter with DWELL_CYCLES-1 and go to DWELL.
- DWELL:
  - Counter decrements each cycle.
  - When counter==0 and abort=0, the step is applied on that edge: level_out <= next() if up, prev() if down.
  - After the step: if the new level equals the target, go to DONE; else reload the counter and stay in DWELL.
  - Each step therefore takes exactly DWELL_CYCLES cycles.
  - Wrap-around never occurs, because direction is chosen by numeric comparison.
- DONE: done=1 for one cycle, then return to IDLE. req_ready is 0 in DONE.
- Latency: accept at edge E0, k steps.
  - Level changes at E0 + n·DWELL_CYCLES for n=1..k.
  - done is high in the cycle after edge E0 + k·DWELL_CYCLES.
  - Next request is accepted no earlier than edge E0 + k·DWELL_CYCLES + 2.
- abort:
  - In DWELL: go to IDLE on the next edge, level_out holds, aborted=1 for one cycle, no done pulse.
  - Abort on the same edge as a pending step: abort wins, no step.
  - In IDLE or DONE: ignored.
- req_valid while not ready: ignored; the requester must hold the request.
- Mid-ramp reset: immediate return to reset values, regardless of clk.
- level_idx is registered together with level_out and is always consistent with it.
- err, done and aborted are mutually exclusive.

Optional Feature:
- Macro: ENUM_RAMP_STEP_CNT_EN.
- Defined:
  - Adds output step_cnt (16 bits).
  - Reset to 0; increments by 1 on every applied step.
  - Saturates at 16'hFFFF.
  - Not incremented on err, abort, or a same-target request.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately level_out=E_NONE, level_idx=0, req_ready=1, busy=0, done=err=aborted=0.
- Ramp up (DWELL_CYCLES=4): from E_NONE, accept target E_HIGH at edge 0.
  - level_out becomes E_LOW at edge 4, E_MEDIUM at edge 8, E_HIGH at edge 12.
  - busy is high for 12 cycles, done pulses after edge 12, level_idx=3.
  - step_cnt=3 when the macro is defined.
- Ramp down: from E_HIGH, target E_LOW -> E_MEDIUM at +4, E_LOW at +8, single done pulse, level_idx=1.
- Invalid target: req_target=level_e'(15) -> err pulses for 1 cycle, level_out unchanged, req_ready stays 1, done stays 0.
- Same target: level_out=E_MEDIUM, request E_MEDIUM -> done pulses in the cycle after acceptance, no level change, busy never asserts.
- Abort: E_NONE -> E_MAX, assert abort at edge 6 -> level_out holds E_LOW, aborted pulses once, returns to IDLE, no done.
  - Second case: abort coincident with edge 8 -> no step to E_MEDIUM.
